rr_arb8: RTL and testbench

Eight-way round-robin arbiter that shares one 3-to-8 decoded resource (e.g. a select bus or output bank) between eight requesters. It picks one requester, drives the winning index into the decoder path and presents the decoded one-hot grant. It holds the grant until the owner releases it, then rotates priority. It sits directly in front of the 3-to-8 decoder block and drives that block's enable and select inputs.

---
 rtl/rr_arb8_if.sv | 21 ++
 rtl/rr_arb8.sv | 109 ++++++++++
 tb/tb_rr_arb8.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between requesters and the rr_arb8 arbiter.
// The master side raises requests; the slave side is the arbiter.
interface rr_arb8_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_vld, tmo
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_vld, tmo
  );
endinterface

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter feeding a 3-to-8 decoder; all outputs registered.
// Optional forced release after HOLD_MAX cycles when RR_ARB8_TIMEOUT_EN is defined.
module rr_arb8 #(
  parameter int HOLD_MAX = 4
) (
  input logic       clk,
  input logic       rst_n,
  rr_arb8_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("rr_arb8: HOLD_MAX out of range 1..255");
  end

  logic [0:0] state;
  logic [2:0] ptr;
  logic [2:0] idx_q;
  logic       vld_q;
  logic [7:0] gnt_q;
  logic       tmo_q;

  logic [2:0] win;
  logic [2:0] cand;
  logic       found;
  logic       rel_base;
  logic       rel;
  logic       tmo_hit;

  // First set request at or above ptr, wrapping 7 -> 0.
  always_comb begin
    win   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign rel_base = bus.done
                  | ~bus.req[idx_q]
                  | ~bus.en;

`ifdef RR_ARB8_TIMEOUT_EN
  logic [7:0] cnt;

  // cnt counts completed GRANT cycles; the HOLD_MAX-th edge releases.
  assign tmo_hit = (cnt == 8'(HOLD_MAX - 1));
  assign rel     = rel_base | tmo_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == GRANT && !rel) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign rel     = rel_base;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
      gnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.en && found) begin
            state <= GRANT;
            idx_q <= win;
            vld_q <= 1'b1;
            gnt_q <= 8'd1 << win;
          end
        end
        GRANT: begin
          if (rel) begin
            state <= IDLE;
            vld_q <= 1'b0;
            gnt_q <= '0;
            ptr   <= idx_q + 3'd1;
            tmo_q <= tmo_hit & ~rel_base;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;
  assign bus.tmo     = tmo_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8: rotation, wrap, releases, timeout, reset.
// Expected values are hand-derived from the arbiter behaviour.
module tb_rr_arb8;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  rr_arb8_if bus ();

  rr_arb8 #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic       vld,
                         input logic [2:0] idx,
                         input logic [7:0] g,
                         input logic       t);
    chk({tag, ".vld"}, {7'd0, bus.gnt_vld}, {7'd0, vld});
    chk({tag, ".idx"}, {5'd0, bus.gnt_idx}, {5'd0, idx});
    chk({tag, ".gnt"}, bus.gnt, g);
    chk({tag, ".tmo"}, {7'd0, bus.tmo}, {7'd0, t});
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.req  = 8'hFF;
    bus.done = 1'b0;
    step();
    step();
    chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);

    rst_n = 1'b1;
    step();
    chk_all("first", 1'b1, 3'd0, 8'h01, 1'b0);

    // Full rotation 1..7 then back to 0.
    for (int k = 1; k <= 8; k++) begin
      bus.done = 1'b1;
      step();
      chk_all($sformatf("rot%0d.bub", k), 1'b0,
              3'((k - 1) % 8), 8'h00, 1'b0);
      bus.done = 1'b0;
      step();
      chk_all($sformatf("rot%0d.gnt", k), 1'b1,
              3'(k % 8), 8'd1 << (k % 8), 1'b0);
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;

    // Bring ptr to 6 via a grant to 5.
    bus.req = 8'h20;
    step();
    chk_all("g5", 1'b1, 3'd5, 8'h20, 1'b0);
    bus.req = 8'h05;
    step();
    chk_all("g5.drop", 1'b0, 3'd5, 8'h00, 1'b0);
    step();
    chk_all("wrap0", 1'b1, 3'd0, 8'h01, 1'b0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    chk_all("wrap2", 1'b1, 3'd2, 8'h04, 1'b0);

    // Owner drops its request during a grant to 3.
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = 8'h08;
    step();
    chk_all("g3", 1'b1, 3'd3, 8'h08, 1'b0);
    bus.req = 8'h00;
    step();
    chk_all("g3.drop", 1'b0, 3'd3, 8'h00, 1'b0);

    // Enable drops during a grant.
    bus.req = 8'h08;
    step();
    chk_all("g3b", 1'b1, 3'd3, 8'h08, 1'b0);
    bus.en = 1'b0;
    step();
    chk_all("en.rel", 1'b0, 3'd3, 8'h00, 1'b0);
    step();
    chk_all("en.off1", 1'b0, 3'd3, 8'h00, 1'b0);
    step();
    chk_all("en.off2", 1'b0, 3'd3, 8'h00, 1'b0);
    bus.en = 1'b1;
    step();
    chk_all("en.on", 1'b1, 3'd3, 8'h08, 1'b0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;

    // Long hold on requester 4.
    bus.req = 8'h10;
    step();
    chk_all("g4", 1'b1, 3'd4, 8'h10, 1'b0);
`ifdef RR_ARB8_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      step();
      chk_all($sformatf("hold%0d", c), 1'b1,
              3'd4, 8'h10, 1'b0);
    end
    step();
    chk_all("tmo", 1'b0, 3'd4, 8'h00, 1'b1);
    step();
    chk_all("regrant4", 1'b1, 3'd4, 8'h10, 1'b0);
`else
    for (int c = 2; c <= 22; c++) begin
      step();
      chk_all($sformatf("hold%0d", c), 1'b1,
              3'd4, 8'h10, 1'b0);
    end
`endif
    bus.done = 1'b1;
    step();
    chk_all("g4.rel", 1'b0, 3'd4, 8'h00, 1'b0);
    bus.done = 1'b0;

    // Reset in the middle of a grant to 5.
    bus.req = 8'h20;
    step();
    chk_all("g5b", 1'b1, 3'd5, 8'h20, 1'b0);
    bus.req = 8'hFF;
    rst_n   = 1'b0;
    step();
    chk_all("midrst", 1'b0, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all("postrst", 1'b1, 3'd0, 8'h01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
